// File: rtl/axi4lite_slave_regs.sv
// AXI4-Lite slave register bank: N-1 read/write words plus a read-only
// count of committed writes at the top location.
module axi4lite_slave_regs #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] s_awaddr,
    input  logic                  s_awvalid,
    output logic                  s_awready,
    input  logic [DATA_WIDTH-1:0] s_wdata,
    input  logic                  s_wvalid,
    output logic                  s_wready,
    output logic [1:0]            s_bresp,
    output logic                  s_bvalid,
    input  logic                  s_bready,
    input  logic [ADDR_WIDTH-1:0] s_araddr,
    input  logic                  s_arvalid,
    output logic                  s_arready,
    output logic [DATA_WIDTH-1:0] s_rdata,
    output logic [1:0]            s_rresp,
    output logic                  s_rvalid,
    input  logic                  s_rready
);
    localparam int N = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] CNT_ADDR = ADDR_WIDTH'(N - 1);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic                  aw_held;
    logic                  w_held;
    logic                  bvalid;
    logic                  rvalid;
    logic [ADDR_WIDTH-1:0] aw_addr;
    logic [DATA_WIDTH-1:0] w_data;
    logic [DATA_WIDTH-1:0] counter;
    logic [DATA_WIDTH-1:0] rdata;
    logic [DATA_WIDTH-1:0] rd_value;
    logic [1:0]            bresp;
    logic [DATA_WIDTH-1:0] regs [N-1];
    logic                  aw_hs;
    logic                  w_hs;
    logic                  ar_hs;
    logic                  commit;

    assign s_awready = !aw_held && !bvalid;
    assign s_wready  = !w_held && !bvalid;
    assign s_arready = !rvalid;
    assign s_bvalid  = bvalid;
    assign s_bresp   = bresp;
    assign s_rvalid  = rvalid;
    assign s_rdata   = rdata;
    assign s_rresp   = RESP_OKAY;

    assign aw_hs  = s_awvalid && s_awready;
    assign w_hs   = s_wvalid && s_wready;
    assign ar_hs  = s_arvalid && s_arready;
    assign commit = aw_held && w_held && !bvalid;

    // AW and W are captured independently; the write commits once both are held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            aw_addr <= '0;
            w_data  <= '0;
            bvalid  <= 1'b0;
            bresp   <= RESP_OKAY;
            counter <= '0;
        end else begin
            if (aw_hs) begin
                aw_held <= 1'b1;
                aw_addr <= s_awaddr;
            end
            if (w_hs) begin
                w_held <= 1'b1;
                w_data <= s_wdata;
            end
            if (commit) begin
                aw_held <= 1'b0;
                w_held  <= 1'b0;
                bvalid  <= 1'b1;
                if (aw_addr == CNT_ADDR) begin
                    bresp <= RESP_SLVERR;
                end else begin
                    bresp   <= RESP_OKAY;
                    counter <= counter + DATA_WIDTH'(1);
                end
            end else if (bvalid && s_bready) begin
                bvalid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N - 1; i++) regs[i] <= '0;
        end else if (commit) begin
            for (int i = 0; i < N - 1; i++) begin
                if (aw_addr == ADDR_WIDTH'(i)) regs[i] <= w_data;
            end
        end
    end

    // The top location falls through to the write counter.
    always_comb begin
        rd_value = counter;
        for (int i = 0; i < N - 1; i++) begin
            if (s_araddr == ADDR_WIDTH'(i)) rd_value = regs[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else if (ar_hs) begin
            rvalid <= 1'b1;
            rdata  <= rd_value;
        end else if (rvalid && s_rready) begin
            rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4lite_slave_regs.sv
// Self-checking bench for axi4lite_slave_regs: vector table plus hand-written
// multi-cycle sequences, with response scoreboards for B and R.
module tb_axi4lite_slave_regs;
    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] s_awaddr;
    logic       s_awvalid;
    logic       s_awready;
    logic [7:0] s_wdata;
    logic       s_wvalid;
    logic       s_wready;
    logic [1:0] s_bresp;
    logic       s_bvalid;
    logic       s_bready;
    logic [1:0] s_araddr;
    logic       s_arvalid;
    logic       s_arready;
    logic [7:0] s_rdata;
    logic [1:0] s_rresp;
    logic       s_rvalid;
    logic       s_rready;

    int tests  = 0;
    int failed = 0;

    logic [1:0] bq [$];
    logic [9:0] rq [$];
    logic [7:0] model_regs [3];
    logic [7:0] model_cnt;

    typedef struct {
        bit         is_write;
        logic [1:0] addr;
        logic [7:0] data;
        int         aw_delay;
        int         w_delay;
        logic [7:0] exp_data;
        logic [1:0] exp_resp;
    } vec_t;

    vec_t vecs [16];

    always #5 clk = ~clk;

    axi4lite_slave_regs #(.ADDR_WIDTH(2), .DATA_WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .s_awaddr  (s_awaddr),
        .s_awvalid (s_awvalid),
        .s_awready (s_awready),
        .s_wdata   (s_wdata),
        .s_wvalid  (s_wvalid),
        .s_wready  (s_wready),
        .s_bresp   (s_bresp),
        .s_bvalid  (s_bvalid),
        .s_bready  (s_bready),
        .s_araddr  (s_araddr),
        .s_arvalid (s_arvalid),
        .s_arready (s_arready),
        .s_rdata   (s_rdata),
        .s_rresp   (s_rresp),
        .s_rvalid  (s_rvalid),
        .s_rready  (s_rready)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic doReset();
        rst_n     = 1'b0;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        s_bready  = 1'b1;
        s_rready  = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) model_regs[i] = 8'h00;
        model_cnt = 8'h00;
    endtask

    task automatic applyWrite(input logic [1:0] addr, input logic [7:0] data, input int aw_delay,
                              input int w_delay, input logic [1:0] exp_resp, input int hold);
        int         cyc = 0;
        int         lat = 0;
        bit         aw_done = 0;
        bit         w_done = 0;
        bit         hs_aw;
        bit         hs_w;
        logic [1:0] e;
        bq.push_back(exp_resp);
        s_awaddr = addr;
        s_wdata  = data;
        while (!(aw_done && w_done) && cyc < 40) begin
            s_awvalid = !aw_done && (cyc >= aw_delay);
            s_wvalid  = !w_done && (cyc >= w_delay);
            hs_aw = s_awvalid && s_awready;
            hs_w  = s_wvalid && s_wready;
            @(posedge clk);
            #1;
            cyc++;
            if (hs_aw) aw_done = 1;
            if (hs_w) w_done = 1;
            if (w_done && !aw_done) checkOutput("wready_while_held", 32'(s_wready), 0);
            if (aw_done && !w_done) checkOutput("awready_while_held", 32'(s_awready), 0);
        end
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        checkOutput("w_handshakes", 32'(aw_done && w_done), 1);
        while (!s_bvalid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("b_latency", 32'(lat), 1);
        e = bq.pop_front();
        checkOutput("b_resp", 32'(s_bresp), 32'(e));
        if (hold > 0) begin
            s_bready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(posedge clk);
                #1;
                checkOutput("b_hold_valid", 32'(s_bvalid), 1);
                checkOutput("b_hold_resp", 32'(s_bresp), 32'(e));
                checkOutput("b_hold_awready", 32'(s_awready), 0);
                checkOutput("b_hold_wready", 32'(s_wready), 0);
            end
            s_bready = 1'b1;
        end
        @(posedge clk);
        #1;
        checkOutput("b_one_cycle", 32'(s_bvalid), 0);
    endtask

    task automatic applyRead(input logic [1:0] addr, input logic [7:0] exp_data);
        int         n = 0;
        logic [9:0] e;
        rq.push_back({OKAY, exp_data});
        s_araddr  = addr;
        s_arvalid = 1'b1;
        while (!s_arready && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
        checkOutput("r_valid", 32'(s_rvalid), 1);
        e = rq.pop_front();
        checkOutput("r_data", 32'(s_rdata), 32'(e[7:0]));
        checkOutput("r_resp", 32'(s_rresp), 32'(e[9:8]));
        @(posedge clk);
        #1;
        checkOutput("r_one_cycle", 32'(s_rvalid), 0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0]  = '{0, 2'd0, 8'h00, 0, 0, 8'h00, OKAY};
        vecs[1]  = '{0, 2'd1, 8'h00, 0, 0, 8'h00, OKAY};
        vecs[2]  = '{0, 2'd2, 8'h00, 0, 0, 8'h00, OKAY};
        vecs[3]  = '{0, 2'd3, 8'h00, 0, 0, 8'h00, OKAY};
        vecs[4]  = '{1, 2'd2, 8'h04, 0, 0, 8'h00, OKAY};
        vecs[5]  = '{0, 2'd2, 8'h00, 0, 0, 8'h04, OKAY};
        vecs[6]  = '{0, 2'd3, 8'h00, 0, 0, 8'h01, OKAY};
        vecs[7]  = '{1, 2'd1, 8'hA5, 3, 0, 8'h00, OKAY};
        vecs[8]  = '{0, 2'd1, 8'h00, 0, 0, 8'hA5, OKAY};
        vecs[9]  = '{1, 2'd1, 8'hA5, 0, 3, 8'h00, OKAY};
        vecs[10] = '{0, 2'd1, 8'h00, 0, 0, 8'hA5, OKAY};
        vecs[11] = '{1, 2'd3, 8'h55, 0, 0, 8'h00, SLVERR};
        vecs[12] = '{0, 2'd3, 8'h00, 0, 0, 8'h03, OKAY};
        vecs[13] = '{1, 2'd0, 8'hC7, 1, 1, 8'h00, OKAY};
        vecs[14] = '{0, 2'd0, 8'h00, 0, 0, 8'hC7, OKAY};
        vecs[15] = '{0, 2'd3, 8'h00, 0, 0, 8'h04, OKAY};

        s_awaddr = 2'd0;
        s_wdata  = 8'h00;
        s_araddr = 2'd0;
        doReset();

        checkOutput("idle_awready", 32'(s_awready), 1);
        checkOutput("idle_wready", 32'(s_wready), 1);
        checkOutput("idle_arready", 32'(s_arready), 1);
        checkOutput("idle_bvalid", 32'(s_bvalid), 0);
        checkOutput("idle_rvalid", 32'(s_rvalid), 0);
        checkOutput("idle_bresp", 32'(s_bresp), 0);
        checkOutput("idle_rdata", 32'(s_rdata), 0);

        for (int i = 0; i < 16; i++) begin
            if (vecs[i].is_write)
                applyWrite(vecs[i].addr, vecs[i].data, vecs[i].aw_delay, vecs[i].w_delay, vecs[i].exp_resp, 0);
            else
                applyRead(vecs[i].addr, vecs[i].exp_data);
        end

        // SLVERR response held with bready low; the counter is untouched
        applyWrite(2'd3, 8'h55, 0, 0, SLVERR, 5);
        applyRead(2'd3, 8'h04);

        // Counter wrap from a clean reset
        doReset();
        for (int i = 0; i < 255; i++) begin
            applyWrite(2'(i % 3), 8'(i), 0, 0, OKAY, 0);
            model_regs[i % 3] = 8'(i);
            model_cnt = model_cnt + 8'd1;
        end
        applyRead(2'd3, model_cnt);
        applyRead(2'd3, 8'hFF);
        applyWrite(2'd0, 8'h99, 0, 0, OKAY, 0);
        model_regs[0] = 8'h99;
        model_cnt = model_cnt + 8'd1;
        applyRead(2'd3, 8'h00);
        applyRead(2'd1, model_regs[1]);

        // AR on the same edge as a commit to the same location sees old data
        bq.push_back(OKAY);
        rq.push_back({OKAY, model_regs[0]});
        s_awaddr  = 2'd0;
        s_wdata   = 8'h42;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        @(posedge clk);
        #1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_araddr  = 2'd0;
        s_arvalid = 1'b1;
        checkOutput("same_edge_b_early", 32'(s_bvalid), 0);
        @(posedge clk);
        #1;
        s_arvalid = 1'b0;
        checkOutput("same_edge_bvalid", 32'(s_bvalid), 1);
        checkOutput("same_edge_rvalid", 32'(s_rvalid), 1);
        begin
            logic [1:0] eb;
            logic [9:0] er;
            eb = bq.pop_front();
            er = rq.pop_front();
            checkOutput("same_edge_bresp", 32'(s_bresp), 32'(eb));
            checkOutput("same_edge_rdata", 32'(s_rdata), 32'(er[7:0]));
        end
        @(posedge clk);
        #1;
        model_regs[0] = 8'h42;
        model_cnt = model_cnt + 8'd1;
        applyRead(2'd0, 8'h42);
        applyRead(2'd3, model_cnt);

        // Reset with both responses pending drops them at once
        s_bready  = 1'b0;
        s_rready  = 1'b0;
        s_awaddr  = 2'd1;
        s_wdata   = 8'h77;
        s_awvalid = 1'b1;
        s_wvalid  = 1'b1;
        s_araddr  = 2'd0;
        s_arvalid = 1'b1;
        @(posedge clk);
        #1;
        s_awvalid = 1'b0;
        s_wvalid  = 1'b0;
        s_arvalid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("pre_reset_bvalid", 32'(s_bvalid), 1);
        checkOutput("pre_reset_rvalid", 32'(s_rvalid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_bvalid", 32'(s_bvalid), 0);
        checkOutput("async_reset_rvalid", 32'(s_rvalid), 0);
        checkOutput("async_reset_rdata", 32'(s_rdata), 0);
        checkOutput("async_reset_bresp", 32'(s_bresp), 0);
        @(negedge clk);
        rst_n    = 1'b1;
        s_bready = 1'b1;
        s_rready = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_reset_awready", 32'(s_awready), 1);
        checkOutput("post_reset_wready", 32'(s_wready), 1);
        checkOutput("post_reset_arready", 32'(s_arready), 1);
        checkOutput("post_reset_bvalid", 32'(s_bvalid), 0);
        for (int a = 0; a < 4; a++) applyRead(2'(a), 8'h00);

        checkOutput("scoreboard_empty", 32'(bq.size() + rq.size()), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
